uart_rx_os: RTL and testbench

Standalone UART receiver: the far end of the link driven by the existing transmitter's txd pin. It runs on the system clock with its own 16x oversampling tick divider and a 2-FF input synchronizer. Frame: start bit, 8 data bits (LSB first), optional parity bit, 1 stop bit. Received bytes go to a one-deep holding register with a valid/ready handshake and an overrun flag.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_os_if.sv | 26 ++
 rtl/uart_os_tick.sv | 28 ++
 rtl/uart_rx_os.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the oversampling UART receiver.
//   state_t  - receiver frame state
//   DATA_W   - width of one received character
//   calc_div - clocks per oversampling tick, floor(clk/(baud*over)), never below 1
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } state_t;

  function automatic int calc_div(input int clk_freq, input int baud, input int over);
    int d;
    d = clk_freq / (baud * over);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: received-byte handshake between the UART receiver and its consumer.
//   data_out     - received byte (receiver -> consumer)
//   valid_rx     - data_out holds an unconsumed byte
//   parity_error - parity status of the byte in data_out
//   stop_error   - stop bit was sampled low for the byte in data_out
//   data_ready   - consumer accepts data_out while valid_rx is high (consumer -> receiver)
interface uart_rx_os_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] data_out;
  logic              valid_rx;
  logic              parity_error;
  logic              stop_error;
  logic              data_ready;

  modport master (
    output data_out, valid_rx, parity_error, stop_error,
    input  data_ready
  );

  modport slave (
    input  data_out, valid_rx, parity_error, stop_error,
    output data_ready
  );

endinterface

// File: rtl/uart_os_tick.sv
// uart_os_tick: free-running divider producing the oversampling tick.
//   clk     - system clock
//   reset   - asynchronous active-low reset
//   os_tick - one clock high each time the counter wraps (every clock when DIV = 1)
module uart_os_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic os_tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    os_tick = (cnt_q == LAST);
    cnt_d   = os_tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: UART receiver with 16x-style oversampling and a one-deep output register.
// Frame: start, 8 data bits LSB first, optional parity, 1 stop bit.
//   clk     - system clock
//   reset   - asynchronous active-low reset
//   rxd     - asynchronous serial input, idle high
//   rx_if   - received byte handshake (data_out/valid_rx/flags out, data_ready in)
//   overrun - one-clock pulse when a completed frame is dropped
//   busy    - high from start-edge detection until the receiver is idle again
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVER       = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rxd,
  uart_rx_os_if.master   rx_if,
  output logic           overrun,
  output logic           busy
);

  localparam int             DIV     = calc_div(CLK_FREQ, BAUD_RATE, OVER);
  localparam int             SCW     = $clog2(OVER);
  localparam logic [SCW-1:0] SC_HALF = SCW'(OVER / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVER - 1);
  localparam logic           ODD_BIT = (PARITY_ODD != 0);

  logic os_tick;

  uart_os_tick #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset   (reset),
    .os_tick (os_tick)
  );

  logic              rx_meta_q, rx_s_q;
  state_t            state_q, state_d;
  logic [SCW-1:0]    sc_q, sc_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              fperr_q, fperr_d;
  logic              stop_bit_q, stop_bit_d;
  logic              stop_done_q, stop_done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              serr_q, serr_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    sc_d        = sc_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    fperr_d     = fperr_q;
    stop_bit_d  = stop_bit_q;
    stop_done_d = 1'b0;
    busy_d      = busy_q;
    data_d      = data_q;
    valid_d     = valid_q;
    perr_d      = perr_q;
    serr_d      = serr_q;
    overrun_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          sc_d    = '0;
          shift_d = '0;
          fperr_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (os_tick) begin
          if (sc_q == SC_HALF) begin
            // Mid-start sample high means the low level was a glitch.
            if (rx_s_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end else begin
              sc_d    = '0;
              idx_d   = '0;
              state_d = DATA;
            end
          end else begin
            sc_d = sc_q + SCW'(1);
          end
        end
      end
      DATA: begin
        if (os_tick) begin
          if (sc_q == SC_LAST) begin
            sc_d           = '0;
            shift_d[idx_q] = rx_s_q;
            if (idx_q == 3'd7) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            else               idx_d   = idx_q + 3'd1;
          end else begin
            sc_d = sc_q + SCW'(1);
          end
        end
      end
      PARITY: begin
        if (os_tick) begin
          if (sc_q == SC_LAST) begin
            sc_d    = '0;
            fperr_d = ((^shift_q) ^ rx_s_q) != ODD_BIT;
            state_d = STOP;
          end else begin
            sc_d = sc_q + SCW'(1);
          end
        end
      end
      STOP: begin
        // The clock after the stop sample is the commit clock; leave STOP then.
        if (stop_done_q) begin
          state_d = stop_bit_q ? IDLE : BREAK_WAIT;
          busy_d  = ~stop_bit_q;
        end else if (os_tick) begin
          if (sc_q == SC_LAST) begin
            sc_d        = '0;
            stop_bit_d  = rx_s_q;
            stop_done_d = 1'b1;
          end else begin
            sc_d = sc_q + SCW'(1);
          end
        end
      end
      BREAK_WAIT: begin
        // A held-low line yields a single frame; wait for it to go idle.
        if (rx_s_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // A commit may replace a byte being consumed in the same clock.
    if (stop_done_q) begin
      if (!valid_q || rx_if.data_ready) begin
        data_d  = shift_q;
        perr_d  = (PARITY_EN != 0) ? fperr_q : 1'b0;
        serr_d  = ~stop_bit_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_if.data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      sc_q        <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      fperr_q     <= 1'b0;
      stop_bit_q  <= 1'b1;
      stop_done_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      serr_q      <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= rxd;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      sc_q        <= sc_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      fperr_q     <= fperr_d;
      stop_bit_q  <= stop_bit_d;
      stop_done_q <= stop_done_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      serr_q      <= serr_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_if.data_out     = data_q;
  assign rx_if.valid_rx     = valid_q;
  assign rx_if.parity_error = perr_q;
  assign rx_if.stop_error   = serr_q;
  assign overrun            = overrun_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: bench for uart_rx_os at 16 clocks per bit (DIV = 1), even parity.
// Directed scenarios with literal expectations, then randomized frames, glitches
// and consumer stalls, with every cycle compared against a timing-level model.
module tb_uart_rx_os;

  localparam int OVER = 16;
  localparam int BITC = 16;
  localparam int MAXC = 20000;

  localparam int M_IDLE   = 0;
  localparam int M_FRAME  = 1;
  localparam int M_COMMIT = 2;
  localparam int M_BW     = 3;

  logic clk = 1'b0;
  logic reset;
  logic rxd;
  logic overrun;
  logic busy;

  uart_rx_os_if rx_if ();

  uart_rx_os #(
    .CLK_FREQ   (1600000),
    .BAUD_RATE  (100000),
    .OVER       (OVER),
    .PARITY_EN  (1),
    .PARITY_ODD (0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rxd     (rxd),
    .rx_if   (rx_if),
    .overrun (overrun),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int ovr_cnt = 0;
  int n = 0;
  logic rnd_dr = 1'b0;

  logic rxd_hist [MAXC];
  logic dr_hist  [MAXC];

  // Model: receiver timing expressed as absolute sample instants after detection.
  int         m_mode, m_t0, m_idle_from, m_bw_from;
  logic [7:0] m_bits;
  logic       m_par, m_stop;
  logic       e_val, e_perr, e_serr, e_ovr, e_busy;
  logic [7:0] e_dat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_t0 = 0; m_idle_from = 0; m_bw_from = 0;
    m_bits = '0; m_par = 1'b0; m_stop = 1'b1;
    e_val = 1'b0; e_dat = '0; e_perr = 1'b0; e_serr = 1'b0; e_ovr = 1'b0; e_busy = 1'b0;
  endtask

  // Advance the model across clock edge e, which sees the inputs of cycle e-1.
  task automatic model_step(input int e);
    int   p;
    logic rs, dr, commit;
    p      = e - 1;
    rs     = (p >= 2 && p - 2 < MAXC) ? rxd_hist[p-2] : 1'b1;
    dr     = (p >= 0 && p < MAXC) ? dr_hist[p] : 1'b0;
    commit = 1'b0;
    e_ovr  = 1'b0;
    case (m_mode)
      M_IDLE: if (p >= m_idle_from && !rs) begin
        m_mode = M_FRAME; m_t0 = p; e_busy = 1'b1; m_bits = '0;
      end
      M_FRAME: begin
        if (p == m_t0 + OVER/2 && rs) begin
          m_mode = M_IDLE; e_busy = 1'b0; m_idle_from = p + 1;
        end
        for (int i = 0; i < 8; i++)
          if (p == m_t0 + OVER/2 + BITC*(i+1)) m_bits[i] = rs;
        if (p == m_t0 + OVER/2 + BITC*9) m_par = rs;
        if (p == m_t0 + OVER/2 + BITC*10) begin
          m_stop = rs; m_mode = M_COMMIT;
        end
      end
      M_COMMIT: begin
        commit = 1'b1;
        if (m_stop) begin m_mode = M_IDLE; e_busy = 1'b0; m_idle_from = e; end
        else        begin m_mode = M_BW;   m_bw_from = e; end
      end
      default: if (p >= m_bw_from && rs) begin
        m_mode = M_IDLE; e_busy = 1'b0; m_idle_from = p + 1;
      end
    endcase
    if (commit) begin
      if (!e_val || dr) begin
        e_val  = 1'b1;
        e_dat  = m_bits;
        e_perr = ($countones({m_bits, m_par}) % 2) != 0;
        e_serr = !m_stop;
      end else begin
        e_ovr = 1'b1;
      end
    end else if (e_val && dr) begin
      e_val = 1'b0;
    end
  endtask

  initial begin : compare
    logic rst_e;
    logic [12:0] act, exp;
    model_reset();
    forever begin
      @(posedge clk);
      n++;
      rst_e = reset;
      @(negedge clk);
      if (n < MAXC) begin
        rxd_hist[n] = rxd;
        dr_hist[n]  = rx_if.data_ready;
      end
      if (!rst_e || !reset) model_reset();
      else                  model_step(n);
      act = {rx_if.valid_rx, rx_if.data_out, rx_if.parity_error, rx_if.stop_error, overrun, busy};
      exp = {e_val, e_dat, e_perr, e_serr, e_ovr, e_busy};
      checks++;
      if (act === exp) passes++;
      else $display("FAIL cycle %0d model {valid,data,perr,serr,ovr,busy}: got %b_%h_%b%b%b%b, expected %b_%h_%b%b%b%b",
                    n, act[12], act[11:4], act[3], act[2], act[1], act[0],
                    exp[12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
      if (overrun === 1'b1) ovr_cnt++;
    end
  end

  task automatic cyc(input int k);
    for (int i = 0; i < k; i++) begin
      if (rnd_dr) rx_if.data_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    cyc(BITC);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stp);
    rxd = 1'b1;
  endtask

  task automatic accept();
    rx_if.data_ready = 1'b1;
    cyc(1);
    rx_if.data_ready = 1'b0;
  endtask

  initial begin : stim
    int ovr0;
    logic [7:0] d;
    logic par;
    reset = 1'b0;
    rxd = 1'b1;
    rx_if.data_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(rx_if.valid_rx), 32'd0);
    chk("reset_data", 32'(rx_if.data_out), 32'h00);
    chk("reset_busy_ovr", 32'({busy, overrun, rx_if.parity_error, rx_if.stop_error}), 32'd0);
    reset = 1'b1;
    cyc(5);

    // 1: good frame 0xA5, then acceptance clears valid one clock later
    send_frame(8'hA5, 1'b0, 1'b1);
    cyc(2);
    chk("a5_valid", 32'(rx_if.valid_rx), 32'd1);
    chk("a5_data", 32'(rx_if.data_out), 32'hA5);
    chk("a5_flags", 32'({rx_if.parity_error, rx_if.stop_error}), 32'd0);
    chk("a5_busy", 32'(busy), 32'd0);
    accept();
    chk("a5_consumed", 32'(rx_if.valid_rx), 32'd0);
    chk("a5_hold", 32'(rx_if.data_out), 32'hA5);

    // 2: wrong parity
    send_frame(8'h3C, 1'b1, 1'b1);
    cyc(2);
    chk("3c_data", 32'(rx_if.data_out), 32'h3C);
    chk("3c_flags", 32'({rx_if.parity_error, rx_if.stop_error}), 32'b10);
    accept();

    // 3: false start
    rxd = 1'b0;
    cyc(6);
    rxd = 1'b1;
    cyc(3);
    chk("glitch_busy_hi", 32'(busy), 32'd1);
    cyc(20);
    chk("glitch_busy_lo", 32'(busy), 32'd0);
    chk("glitch_valid", 32'(rx_if.valid_rx), 32'd0);

    // 4: overrun
    ovr0 = ovr_cnt;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    cyc(2);
    chk("ovr_valid", 32'(rx_if.valid_rx), 32'd1);
    chk("ovr_data", 32'(rx_if.data_out), 32'h11);
    chk("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
    accept();

    // 5: break, then a normal frame
    ovr0 = ovr_cnt;
    rxd = 1'b0;
    cyc(30 * BITC);
    chk("brk_busy", 32'(busy), 32'd1);
    rxd = 1'b1;
    cyc(20);
    chk("brk_valid", 32'(rx_if.valid_rx), 32'd1);
    chk("brk_data", 32'(rx_if.data_out), 32'h00);
    chk("brk_flags", 32'({rx_if.parity_error, rx_if.stop_error}), 32'b01);
    chk("brk_idle", 32'(busy), 32'd0);
    accept();
    send_frame(8'h5A, 1'b0, 1'b1);
    cyc(2);
    chk("5a_data", 32'(rx_if.data_out), 32'h5A);
    chk("5a_flags", 32'({rx_if.valid_rx, rx_if.parity_error, rx_if.stop_error}), 32'b100);
    chk("brk_no_ovr", 32'(ovr_cnt - ovr0), 32'd0);

    // 6: asynchronous reset in data bit 4 of 0xFF (0x5A left unconsumed)
    rxd = 1'b0;
    cyc(BITC);
    rxd = 1'b1;
    cyc(BITC * 4 + 8);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid_busy", 32'({rx_if.valid_rx, busy}), 32'd0);
    chk("arst_data", 32'(rx_if.data_out), 32'h00);
    cyc(3);
    reset = 1'b1;
    cyc(5);
    send_frame(8'h81, 1'b0, 1'b1);
    cyc(2);
    chk("81_data", 32'(rx_if.data_out), 32'h81);
    chk("81_flags", 32'({rx_if.valid_rx, rx_if.parity_error, rx_if.stop_error}), 32'b100);
    accept();

    // Randomized traffic with a stalling consumer
    rnd_dr = 1'b1;
    for (int f = 0; f < 14; f++) begin
      if ($urandom_range(0, 4) == 0) begin
        rxd = 1'b0;
        cyc($urandom_range(1, 6));
        rxd = 1'b1;
        cyc($urandom_range(12, 30));
      end
      d   = 8'($urandom);
      par = ^d;
      if ($urandom_range(0, 3) == 0) par = ~par;
      send_frame(d, par, ($urandom_range(0, 4) != 0));
      cyc($urandom_range(2, 40));
    end
    rnd_dr = 1'b0;
    rx_if.data_ready = 1'b1;
    cyc(200);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
